// File: rtl/sync_edge_filter.sv
// Glitch filter for a synchronized clkB-domain level: qualifies level changes over
// FILTER_CYCLES samples, emits rise/fall pulses and keeps a saturating rise counter.
module sync_edge_filter #(
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clkB,
  input  logic             rstB,
  input  logic             SignalIn_clkB,
  input  logic             CountClr_clkB,
  output logic             Level_clkB,
  output logic             Rise_clkB,
  output logic             Fall_clkB,
  output logic [CNT_W-1:0] EventCount_clkB,
  output logic             Overflow_clkB
);

  localparam int unsigned     QW      = $clog2(FILTER_CYCLES + 1);
  localparam logic [QW-1:0]   QLAST   = QW'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    LOW_STABLE,
    QUAL_HIGH,
    HIGH_STABLE,
    QUAL_LOW
  } state_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW_STABLE: begin
        if (SignalIn_clkB) begin
          if (FILTER_CYCLES == 1) begin
            state_d = HIGH_STABLE;
            qcnt_d  = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = QUAL_HIGH;
            qcnt_d  = QW'(1);
          end
        end
      end
      QUAL_HIGH: begin
        if (!SignalIn_clkB) begin
          state_d = LOW_STABLE;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = HIGH_STABLE;
          qcnt_d  = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!SignalIn_clkB) begin
          if (FILTER_CYCLES == 1) begin
            state_d = LOW_STABLE;
            qcnt_d  = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = QUAL_LOW;
            qcnt_d  = QW'(1);
          end
        end
      end
      QUAL_LOW: begin
        if (SignalIn_clkB) begin
          state_d = HIGH_STABLE;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = LOW_STABLE;
          qcnt_d  = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        qcnt_d  = '0;
      end
    endcase
  end

  // Clear is applied before the rise, so a simultaneous clear+rise leaves count=1.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (CountClr_clkB) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end
    if (rise_d) begin
      if (count_d == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clkB) begin
    if (rstB) begin
      state_q <= LOW_STABLE;
      qcnt_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Level_clkB      = level_q;
  assign Rise_clkB       = rise_q;
  assign Fall_clkB       = fall_q;
  assign EventCount_clkB = count_q;
  assign Overflow_clkB   = ovf_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed bench for sync_edge_filter: F=3/8-bit, F=3/2-bit and an F=1 instance
// fed through a two-flop synchronizer from a clkA source.
module tb_sync_edge_filter;

  logic clkA = 1'b0;
  logic clkB = 1'b0;
  logic rstB = 1'b1;
  always #1 clkA = ~clkA;
  always #2 clkB = ~clkB;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic in1 = 1'b0, clr1 = 1'b0;
  logic lvl1, rise1, fall1, ovf1;
  logic [7:0] cnt1;
  logic [11:0] obs1;
  assign obs1 = {lvl1, rise1, fall1, ovf1, cnt1};

  logic in2 = 1'b0, clr2 = 1'b0;
  logic lvl2, rise2, fall2, ovf2;
  logic [1:0] cnt2;
  logic [5:0] obs2;
  assign obs2 = {lvl2, rise2, fall2, ovf2, cnt2};

  logic src_next = 1'b0, src_a, s1, s2, clr3 = 1'b0;
  logic lvl3, rise3, fall3, ovf3;
  logic [7:0] cnt3;
  logic [11:0] obs3;
  assign obs3 = {lvl3, rise3, fall3, ovf3, cnt3};

  always @(posedge clkA) src_a <= rstB ? 1'b0 : src_next;
  always @(posedge clkB) begin
    s1 <= rstB ? 1'b0 : src_a;
    s2 <= rstB ? 1'b0 : s1;
  end

  sync_edge_filter #(.FILTER_CYCLES(3), .CNT_W(8)) u_f3 (
    .clkB(clkB), .rstB(rstB), .SignalIn_clkB(in1), .CountClr_clkB(clr1),
    .Level_clkB(lvl1), .Rise_clkB(rise1), .Fall_clkB(fall1),
    .EventCount_clkB(cnt1), .Overflow_clkB(ovf1));

  sync_edge_filter #(.FILTER_CYCLES(3), .CNT_W(2)) u_sat (
    .clkB(clkB), .rstB(rstB), .SignalIn_clkB(in2), .CountClr_clkB(clr2),
    .Level_clkB(lvl2), .Rise_clkB(rise2), .Fall_clkB(fall2),
    .EventCount_clkB(cnt2), .Overflow_clkB(ovf2));

  sync_edge_filter #(.FILTER_CYCLES(1), .CNT_W(8)) u_f1 (
    .clkB(clkB), .rstB(rstB), .SignalIn_clkB(s2), .CountClr_clkB(clr3),
    .Level_clkB(lvl3), .Rise_clkB(rise3), .Fall_clkB(fall3),
    .EventCount_clkB(cnt3), .Overflow_clkB(ovf3));

  task automatic tick();
    @(negedge clkB);
  endtask

  task automatic test_reset();
    rstB = 1'b1; in1 = 1'b0; in2 = 1'b0;
    tick(); tick();
    n_vec++;
    if (obs1 !== 12'h000) begin n_err++; $display("FAIL reset_f3 got %h want %h", obs1, 12'h000); end
    n_vec++;
    if (obs2 !== 6'h00) begin n_err++; $display("FAIL reset_sat got %h want %h", obs2, 6'h00); end
    rstB = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (obs1 !== 12'h000) begin n_err++; $display("FAIL idle_low[%0d] got %h want %h", i, obs1, 12'h000); end
    end
  endtask

  task automatic test_glitch_high();
    logic seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      in1 = seq[i];
      tick();
      n_vec++;
      if (obs1 !== 12'h000) begin n_err++; $display("FAIL glitch_high[%0d] got %h want %h", i, obs1, 12'h000); end
    end
  endtask

  task automatic test_rise();
    logic [11:0] exp [5] = '{12'h000, 12'h000, {4'b1100, 8'd1}, {4'b1000, 8'd1}, {4'b1000, 8'd1}};
    in1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (obs1 !== exp[i]) begin n_err++; $display("FAIL rise[%0d] got %h want %h", i, obs1, exp[i]); end
    end
  endtask

  task automatic test_glitch_low();
    logic seq [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      in1 = seq[i];
      tick();
      n_vec++;
      if (obs1 !== {4'b1000, 8'd1}) begin n_err++; $display("FAIL glitch_low[%0d] got %h want %h", i, obs1, {4'b1000, 8'd1}); end
    end
  endtask

  task automatic test_fall();
    logic [11:0] exp [4] = '{{4'b1000, 8'd1}, {4'b1000, 8'd1}, {4'b0010, 8'd1}, {4'b0000, 8'd1}};
    in1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (obs1 !== exp[i]) begin n_err++; $display("FAIL fall[%0d] got %h want %h", i, obs1, exp[i]); end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      in2 = 1'b1;
      tick(); tick(); tick();
      n_vec++;
      if (obs2 !== {3'b110, eo[i], ec[i]}) begin n_err++; $display("FAIL sat_rise[%0d] got %b want %b", i, obs2, {3'b110, eo[i], ec[i]}); end
      in2 = 1'b0;
      tick(); tick(); tick();
      n_vec++;
      if (obs2 !== {3'b001, eo[i], ec[i]}) begin n_err++; $display("FAIL sat_fall[%0d] got %b want %b", i, obs2, {3'b001, eo[i], ec[i]}); end
    end
    clr2 = 1'b1;
    tick();
    n_vec++;
    if (obs2 !== 6'b000000) begin n_err++; $display("FAIL sat_clear got %b want %b", obs2, 6'b000000); end
    clr2 = 1'b0;
    tick();
    n_vec++;
    if (obs2 !== 6'b000000) begin n_err++; $display("FAIL sat_after_clear got %b want %b", obs2, 6'b000000); end
  endtask

  task automatic test_clr_with_rise();
    in1 = 1'b1;
    tick(); tick();
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    n_vec++;
    if (obs1 !== {4'b1100, 8'd1}) begin n_err++; $display("FAIL clr_and_rise got %h want %h", obs1, {4'b1100, 8'd1}); end
    in1 = 1'b0;
    tick(); tick(); tick();
    n_vec++;
    if (obs1 !== {4'b0010, 8'd1}) begin n_err++; $display("FAIL clr_then_fall got %h want %h", obs1, {4'b0010, 8'd1}); end
  endtask

  task automatic test_reset_abort();
    in1 = 1'b1;
    tick();
    n_vec++;
    if (obs1 !== {4'b0000, 8'd1}) begin n_err++; $display("FAIL abort_qual1 got %h want %h", obs1, {4'b0000, 8'd1}); end
    rstB = 1'b1;
    tick();
    n_vec++;
    if (obs1 !== 12'h000) begin n_err++; $display("FAIL abort_reset got %h want %h", obs1, 12'h000); end
    rstB = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (obs1 !== 12'h000) begin n_err++; $display("FAIL abort_requal[%0d] got %h want %h", i, obs1, 12'h000); end
    end
    tick();
    n_vec++;
    if (obs1 !== {4'b1100, 8'd1}) begin n_err++; $display("FAIL abort_rise got %h want %h", obs1, {4'b1100, 8'd1}); end
    in1 = 1'b0;
    tick(); tick(); tick();
  endtask

  // src_next set at a clkB negedge reaches Level three clkB edges later.
  task automatic test_back_to_back();
    logic [2:0] sh = '0;
    logic el, pl = 1'b0, er, ef;
    logic [7:0] ec = '0;
    rstB = 1'b1; src_next = 1'b0;
    tick(); tick();
    rstB = 1'b0;
    for (int i = 0; i < 24; i++) begin
      el = sh[2];
      er = el & ~pl;
      ef = ~el & pl;
      if (er) ec = ec + 8'd1;
      pl = el;
      n_vec++;
      if (obs3 !== {el, er, ef, 1'b0, ec}) begin n_err++; $display("FAIL chain[%0d] got %h want %h", i, obs3, {el, er, ef, 1'b0, ec}); end
      src_next = ~src_next;
      sh = {sh[1:0], src_next};
      tick();
    end
    n_vec++;
    if (cnt3 !== 8'd11) begin n_err++; $display("FAIL chain_count got %0d want %0d", cnt3, 11); end
  endtask

  initial begin
    test_reset();
    test_glitch_high();
    test_rise();
    test_glitch_low();
    test_fall();
    test_saturate();
    test_clr_with_rise();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
